// File: rtl/instr_ctrl_unit_if.sv
// Instruction-memory fetch bus: request/address from the control unit,
// valid/data back from memory.
interface instr_ctrl_unit_if #(
    parameter int unsigned PC_W = 8
) ();
    logic            instr_req;
    logic [PC_W-1:0] instr_addr;
    logic            instr_valid;
    logic [31:0]     instr_data;

    // Control-unit side.
    modport master (
        output instr_req,
        output instr_addr,
        input  instr_valid,
        input  instr_data
    );

    // Instruction-memory side.
    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_valid,
        output instr_data
    );
endinterface

// File: rtl/instr_ctrl_unit.sv
// Multi-cycle fetch/decode/control stage feeding the 8x8 register file.
// Walks FETCH -> DECODE -> EXEC -> WB per instruction; an illegal opcode
// parks the unit in ERROR until reset. All outputs are registered.
module instr_ctrl_unit #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned NREG_AW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_ctrl_unit_if.master    imem,
    output logic [NREG_AW-1:0]   inaddr,
    output logic [NREG_AW-1:0]   out1addr,
    output logic [NREG_AW-1:0]   out2addr,
    output logic                 reg_we,
    output logic [2:0]           alu_sel,
    output logic                 sub_sel,
    output logic                 imm_sel,
    output logic [7:0]           imm,
    output logic [PC_W-1:0]      pc,
    output logic                 illegal
);
    typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StError} state_e;

    localparam logic [7:0] OpLoadi = 8'h00;
    localparam logic [7:0] OpMov   = 8'h01;
    localparam logic [7:0] OpAdd   = 8'h02;
    localparam logic [7:0] OpSub   = 8'h03;
    localparam logic [7:0] OpAnd   = 8'h04;
    localparam logic [7:0] OpOr    = 8'h05;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 instr_req_q, instr_req_d;
    logic                 reg_we_q, reg_we_d;
    logic                 illegal_q, illegal_d;
    logic [7:0]           op_q, op_d;
    logic [NREG_AW-1:0]   inaddr_q, inaddr_d;
    logic [NREG_AW-1:0]   out1addr_q, out1addr_d;
    logic [NREG_AW-1:0]   out2addr_q, out2addr_d;
    logic [2:0]           alu_sel_q, alu_sel_d;
    logic                 sub_sel_q, sub_sel_d;
    logic                 imm_sel_q, imm_sel_d;
    logic [7:0]           imm_q, imm_d;

    // Next-state, PC and control decode; controls load only when a fetch completes.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_req_d = instr_req_q;
        reg_we_d    = 1'b0;
        illegal_d   = illegal_q;
        op_d        = op_q;
        inaddr_d    = inaddr_q;
        out1addr_d  = out1addr_q;
        out2addr_d  = out2addr_q;
        alu_sel_d   = alu_sel_q;
        sub_sel_d   = sub_sel_q;
        imm_sel_d   = imm_sel_q;
        imm_d       = imm_q;

        unique case (state_q)
            StFetch: begin
                instr_req_d = 1'b1;
                // Only a response to an outstanding request is accepted.
                if (imem.instr_valid && instr_req_q) begin
                    instr_req_d = 1'b0;
                    state_d     = StDecode;
                    op_d        = imem.instr_data[31:24];
                    inaddr_d    = imem.instr_data[16 +: NREG_AW];
                    out1addr_d  = imem.instr_data[8 +: NREG_AW];
                    out2addr_d  = imem.instr_data[0 +: NREG_AW];
                    imm_d       = imem.instr_data[7:0];
                    alu_sel_d   = 3'b000;
                    sub_sel_d   = 1'b0;
                    imm_sel_d   = 1'b0;
                    case (imem.instr_data[31:24])
                        OpLoadi: imm_sel_d = 1'b1;
                        OpMov:   alu_sel_d = 3'b000;
                        OpAdd:   alu_sel_d = 3'b001;
                        OpSub: begin
                            alu_sel_d = 3'b001;
                            sub_sel_d = 1'b1;
                        end
                        OpAnd:   alu_sel_d = 3'b010;
                        OpOr:    alu_sel_d = 3'b011;
                        default: alu_sel_d = 3'b000;
                    endcase
                end
            end
            StDecode: begin
                if (op_q <= OpOr) begin
                    state_d = StExec;
                end else begin
                    state_d   = StError;
                    illegal_d = 1'b1;
                end
            end
            StExec: begin
                state_d  = StWb;
                reg_we_d = 1'b1;
            end
            StWb: begin
                state_d     = StFetch;
                instr_req_d = 1'b1;
                pc_d        = pc_q + PC_W'(PC_STEP);
            end
            StError: begin
                instr_req_d = 1'b0;
                illegal_d   = 1'b1;
            end
            default: state_d = StError;
        endcase
    end

    // State register; synchronous reset overrides any pending write or PC step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            instr_req_q <= 1'b0;
            reg_we_q    <= 1'b0;
            illegal_q   <= 1'b0;
            op_q        <= '0;
            inaddr_q    <= '0;
            out1addr_q  <= '0;
            out2addr_q  <= '0;
            alu_sel_q   <= '0;
            sub_sel_q   <= 1'b0;
            imm_sel_q   <= 1'b0;
            imm_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_req_q <= instr_req_d;
            reg_we_q    <= reg_we_d;
            illegal_q   <= illegal_d;
            op_q        <= op_d;
            inaddr_q    <= inaddr_d;
            out1addr_q  <= out1addr_d;
            out2addr_q  <= out2addr_d;
            alu_sel_q   <= alu_sel_d;
            sub_sel_q   <= sub_sel_d;
            imm_sel_q   <= imm_sel_d;
            imm_q       <= imm_d;
        end
    end

    assign imem.instr_req  = instr_req_q;
    assign imem.instr_addr = pc_q;
    assign inaddr          = inaddr_q;
    assign out1addr        = out1addr_q;
    assign out2addr        = out2addr_q;
    assign reg_we          = reg_we_q;
    assign alu_sel         = alu_sel_q;
    assign sub_sel         = sub_sel_q;
    assign imm_sel         = imm_sel_q;
    assign imm             = imm_q;
    assign pc              = pc_q;
    assign illegal         = illegal_q;
endmodule

// File: doc/instr_ctrl_unit.md
Name: instr_ctrl_unit

Overview:
- Multi-cycle fetch/decode/control stage directly upstream of the 8x8-bit register file.
- Fetches 32-bit instructions from instruction memory over a req/valid handshake and keeps the PC.
- Decodes each instruction into register-file read/write addresses, ALU select, immediate and mux controls.
- Produces exactly one register write-enable pulse per legal instruction.

Parameters:
- PC_W, 8, width of byte-addressed program counter.
- PC_STEP, 4, PC increment per instruction (bytes).
- NREG_AW, 3, register address width (8 registers, addresses 0-7).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_req  output  1  fetch request to instruction memory.
- instr_addr  output  PC_W  fetch address, equal to pc.
- instr_valid  input  1  instr_data valid for current request.
- instr_data  input  32  instruction word: OP[31:24] DEST[23:16] SRC1[15:8] SRC2/IMM[7:0].
- inaddr  output  NREG_AW  register write address.
- out1addr  output  NREG_AW  register read port 1 address.
- out2addr  output  NREG_AW  register read port 2 address.
- reg_we  output  1  one-cycle register write strobe.
- alu_sel  output  3  ALU op: 000 forward, 001 add, 010 and, 011 or.
- sub_sel  output  1  1 = negate operand 2 (two's complement) before ALU.
- imm_sel  output  1  1 = operand 2 comes from imm, not out2.
- imm  output  8  immediate, instr_data[7:0].
- pc  output  PC_W  current program counter.
- illegal  output  1  sticky illegal-opcode flag.

Behaviour:
- Reset values (synchronous, active-high): state=FETCH, pc=0, instr_req=0, reg_we=0, illegal=0, all address/control/imm outputs=0. instr_req rises in the first cycle after reset deasserts.
- Opcodes:
  - 0x00 loadi: imm_sel=1, alu_sel=000.
  - 0x01 mov: alu_sel=000, operand SRC2.
  - 0x02 add: 001.
  - 0x03 sub: 001 with sub_sel=1.
  - 0x04 and: 010.
  - 0x05 or: 011.
  - Any other opcode is illegal.
- Register fields: only the low NREG_AW bits of DEST/SRC1/SRC2 are used; upper bits are ignored.
- FSM states: FETCH, DECODE, EXEC, WB, ERROR.
- FETCH: instr_req=1, instr_addr=pc. Stays in FETCH while instr_valid=0. On instr_valid=1, the instruction is latched into an internal IR, instr_req drops, and the FSM goes to DECODE. instr_data is don't-care when instr_valid=0.
- DECODE: inaddr, out1addr, out2addr, alu_sel, sub_sel, imm_sel and imm are driven from IR. Illegal opcode goes to ERROR, otherwise to EXEC.
- EXEC: controls held stable for one cycle so the register-file read and ALU settle. Goes to WB.
- WB: reg_we=1 for exactly this cycle with controls still stable; pc <= pc + PC_STEP (modulo 2^PC_W, so 0xFC wraps to 0x00). Goes to FETCH.
- ERROR: illegal=1, instr_req=0, reg_we=0, pc frozen. Only reset leaves this state.
- Latency: 4 cycles per instruction when instr_valid is returned in the first FETCH cycle; each extra wait cycle adds one.
- Control outputs change only on DECODE entry and hold until the next DECODE.
- Reset in any state, including mid-fetch and in WB, wins over all other activity: no reg_we pulse and no pc update occur on that edge.
- instr_valid arriving outside FETCH is ignored.

Test Plan:
- Reset, then instr_valid=1 with 0x00040005 on the first request -> imm=0x05, imm_sel=1, alu_sel=000, inaddr=4, reg_we high exactly 1 cycle, 4 cycles after the request; pc 0->4.
- 0x02030102 -> out1addr=1, out2addr=2, inaddr=3, alu_sel=001, sub_sel=0, imm_sel=0; single reg_we pulse.
- 0x03070506 then 0x050A0B0C -> first: alu_sel=001, sub_sel=1, inaddr=7. Second: alu_sel=011, inaddr=2, out1addr=3, out2addr=4 (upper bits ignored).
- Hold instr_valid=0 for 3 cycles -> instr_req stays 1, instr_addr stable, no reg_we, pc unchanged; completion comes 3 cycles later than the no-wait case.
- Opcode 0xFF -> illegal=1 after DECODE, instr_req never reasserts, no reg_we, pc frozen. Reset then clears illegal and pc to 0.
- Run to pc=0xFC and execute one instruction -> pc wraps to 0x00. Assert reset during EXEC of an add -> no reg_we pulse, pc=0.
